led_pwm_axi_ctrl: RTL and testbench



---
 rtl/led_ctrl_pkg.sv | 17 +
 rtl/led_pwm_channel.sv | 24 ++
 rtl/led_pwm_axi_ctrl.sv | 165 ++++++++++++++++
 tb/tb_led_pwm_axi_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: register map, AXI response codes, FSM states and byte-strobe merge for led_pwm_axi_ctrl
package led_ctrl_pkg;
    localparam int ADDR_CTRL     = 'h00;
    localparam int ADDR_STATUS   = 'h04;
    localparam int ADDR_PRESCALE = 'h08;
    localparam int ADDR_BLINK    = 'h0C;
    localparam int ADDR_DUTY0    = 'h10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : cur[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: period-boundary duty shadowing and registered PWM compare for one LED
module led_pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] shadow_duty,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 wrap,
    input  logic                 en,
    input  logic                 blink_gate,
    output logic                 led
);
    logic [PWM_WIDTH-1:0] active_duty;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_duty <= '0;
            led         <= 1'b0;
        end else begin
            if (!en || wrap) active_duty <= shadow_duty;
            led <= en && blink_gate && (&active_duty || pwm_cnt < active_duty);
        end
    end
endmodule

// File: rtl/led_pwm_axi_ctrl.sv
// led_pwm_axi_ctrl: AXI4-Lite multi-channel PWM LED controller; define LED_BLINK_EN to add per-channel blinking
module led_pwm_axi_ctrl import led_ctrl_pkg::*; #(
    parameter int          NUM_LEDS           = 4,
    parameter int          PWM_WIDTH          = 8,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 7,
    parameter logic [15:0] PRESCALE_RST       = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             led_o
);
    wr_state_t            w_state;
    rd_state_t            r_state;
    logic                 ctrl_en;
    logic [15:0]          prescale, presc_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [PWM_WIDTH-1:0] duty_sh [NUM_LEDS];
    logic [31:0]          ctrl_word, blink_word, w_new;
    logic [32:0]          w_cur, r_cur;
    logic [NUM_LEDS-1:0]  gate;
    logic                 tick, wrap, w_fire, r_fire, w_err, unused_ok;
    int                   w_word, r_word;
`ifdef LED_BLINK_EN
    logic [3:0]           blink_div;
    logic [NUM_LEDS-1:0]  blink_mask;
    logic [7:0]           period_cnt;
    assign ctrl_word  = {24'b0, blink_div, 3'b0, ctrl_en};
    assign blink_word = 32'(blink_mask);
    assign gate       = ~blink_mask | {NUM_LEDS{!blink_div[3] && period_cnt[blink_div[2:0]]}};
`else
    assign ctrl_word  = {31'b0, ctrl_en};
    assign blink_word = '0;
    assign gate       = '1;
`endif
    // {decode_error, data}; shared by the read path and the write byte-merge
    function automatic logic [32:0] reg_rd(input int word);
        logic [32:0] r;
        r = {1'b1, 32'b0};
        if (word == ADDR_CTRL / 4) r = {1'b0, ctrl_word};
        else if (word == ADDR_STATUS / 4) r = {1'b0, 32'(led_o)};
        else if (word == ADDR_PRESCALE / 4) r = {17'b0, prescale};
        else if (word == ADDR_BLINK / 4) r = {1'b0, blink_word};
        else for (int i = 0; i < NUM_LEDS; i++) if (word == ADDR_DUTY0 / 4 + i) r = {1'b0, 32'(duty_sh[i])};
        return r;
    endfunction
    always_comb begin
        w_word = int'(S_AXI_AWADDR >> 2);
        r_word = int'(S_AXI_ARADDR >> 2);
        w_cur  = reg_rd(w_word);
        r_cur  = reg_rd(r_word);
        w_new  = apply_strb(w_cur[31:0], S_AXI_WDATA, S_AXI_WSTRB);
        w_err  = w_cur[32] || w_word == ADDR_STATUS / 4;
    end
    assign unused_ok = ^w_new;
    assign w_fire    = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign r_fire    = S_AXI_ARREADY && S_AXI_ARVALID;
    assign tick      = presc_cnt >= prescale;
    assign wrap      = tick && &pwm_cnt;
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            ctrl_en       <= 1'b0;
            prescale      <= PRESCALE_RST;
            for (int i = 0; i < NUM_LEDS; i++) duty_sh[i] <= '0;
`ifdef LED_BLINK_EN
            blink_div     <= '0;
            blink_mask    <= '0;
`endif
        end else begin
            S_AXI_AWREADY <= w_state == W_IDLE && !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
            S_AXI_WREADY  <= w_state == W_IDLE && !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
            if (w_fire) begin
                w_state      <= W_RESP;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= w_err ? RESP_SLVERR : RESP_OKAY;
            end else if (w_state == W_RESP && S_AXI_BREADY) begin
                w_state      <= W_IDLE;
                S_AXI_BVALID <= 1'b0;
            end
            if (w_fire && !w_err) begin
                if (w_word == ADDR_CTRL / 4) begin
                    ctrl_en <= w_new[0];
`ifdef LED_BLINK_EN
                    blink_div <= w_new[7:4];
`endif
                end
                if (w_word == ADDR_PRESCALE / 4) prescale <= w_new[15:0];
`ifdef LED_BLINK_EN
                if (w_word == ADDR_BLINK / 4) blink_mask <= w_new[NUM_LEDS-1:0];
`endif
                for (int i = 0; i < NUM_LEDS; i++) if (w_word == ADDR_DUTY0 / 4 + i) duty_sh[i] <= w_new[PWM_WIDTH-1:0];
            end
        end
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= r_state == R_IDLE && !S_AXI_ARREADY && S_AXI_ARVALID;
            if (r_fire) begin
                r_state      <= R_DATA;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= r_cur[31:0];
                S_AXI_RRESP  <= r_cur[32] ? RESP_SLVERR : RESP_OKAY;
            end else if (r_state == R_DATA && S_AXI_RREADY) begin
                r_state      <= R_IDLE;
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
    // >= rather than == so a PRESCALE write below the running count ticks immediately
    always_ff @(posedge ACLK) begin
        if (!ARESETN || !ctrl_en) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
`ifdef LED_BLINK_EN
            period_cnt <= '0;
`endif
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
`ifdef LED_BLINK_EN
            if (wrap) period_cnt <= period_cnt + 1'b1;
`endif
        end
    end
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk        (ACLK),
            .rst_n      (ARESETN),
            .shadow_duty(duty_sh[i]),
            .pwm_cnt    (pwm_cnt),
            .wrap       (wrap),
            .en         (ctrl_en),
            .blink_gate (gate[i]),
            .led        (led_o[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_axi_ctrl.sv
// tb_led_pwm_axi_ctrl: directed register-map vectors plus PWM, handshake, error and reset sequences
module tb_led_pwm_axi_ctrl;
    localparam int N = 4;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b10;
    logic        clk = 1'b0, aresetn = 1'b0;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [N-1:0] led;
    int n_vec = 0, n_err = 0;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    led_pwm_axi_ctrl #(.NUM_LEDS(N), .PWM_WIDTH(8), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .PRESCALE_RST(16'd0)) dut (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .led_o(led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic add(input logic wr, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] rsp, input logic [31:0] rd);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = rsp; v.rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int k;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (awready && wready) break;
        end
        if (k == 20) timeout("wr_addr_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (k = 0; k < 20 && !bvalid; k++) @(negedge clk);
        if (!bvalid) timeout("wr_bvalid");
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (arready) break;
        end
        if (k == 20) timeout("rd_addr_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (k = 0; k < 20 && !rvalid; k++) @(negedge clk);
        if (!rvalid) timeout("rd_rvalid");
        d = rdata;
        resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_rise(input int ch, input int budget, input string name);
        logic prev;
        int k;
        @(negedge clk);
        prev = led[ch];
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (led[ch] && !prev) break;
            prev = led[ch];
        end
        if (k == budget) timeout(name);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int c0, c1, c2, c3, cnt, bad;
`ifdef LED_BLINK_EN
        localparam logic [31:0] CTRL_F0 = 32'hF0, BLINK_F = 32'hF;
`else
        localparam logic [31:0] CTRL_F0 = 32'h0, BLINK_F = 32'h0;
`endif
        add(0, 7'h00, 0, 0, OK, 0);
        add(0, 7'h04, 0, 0, OK, 0);
        add(0, 7'h08, 0, 0, OK, 0);
        add(0, 7'h0C, 0, 0, OK, 0);
        add(0, 7'h10, 0, 0, OK, 0);
        add(0, 7'h14, 0, 0, OK, 0);
        add(0, 7'h18, 0, 0, OK, 0);
        add(0, 7'h1C, 0, 0, OK, 0);
        add(1, 7'h08, 32'h1234_5678, 4'hF, OK, 0);
        add(0, 7'h08, 0, 0, OK, 32'h5678);
        add(1, 7'h09, 32'h0000_AB00, 4'h2, OK, 0);
        add(0, 7'h08, 0, 0, OK, 32'hAB78);
        add(1, 7'h08, 0, 4'hF, OK, 0);
        add(1, 7'h10, 32'h155, 4'hF, OK, 0);
        add(0, 7'h13, 0, 0, OK, 32'h55);
        add(1, 7'h14, 32'hFF, 4'h0, OK, 0);
        add(0, 7'h14, 0, 0, OK, 0);
        add(1, 7'h04, 32'hF, 4'hF, ERR, 0);
        add(0, 7'h04, 0, 0, OK, 0);
        add(1, 7'h20, 32'hAA, 4'hF, ERR, 0);
        add(1, 7'h44, 32'hAA, 4'hF, ERR, 0);
        add(0, 7'h10, 0, 0, OK, 32'h55);
        add(0, 7'h20, 0, 0, ERR, 0);
        add(0, 7'h50, 0, 0, ERR, 0);
        add(0, 7'h7C, 0, 0, ERR, 0);
        add(1, 7'h00, 32'hF0, 4'hF, OK, 0);
        add(0, 7'h00, 0, 0, OK, CTRL_F0);
        add(1, 7'h00, 0, 4'hF, OK, 0);
        add(1, 7'h0C, 32'hF, 4'hF, OK, 0);
        add(0, 7'h0C, 0, 0, OK, BLINK_F);
        add(1, 7'h0C, 0, 4'hF, OK, 0);
        add(1, 7'h10, 0, 4'hF, OK, 0);

        repeat (20) @(posedge clk);
        #1 aresetn = 1'b1;
        @(negedge clk);
        check("rst_led", 32'(led), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_readys", {29'b0, awready, wready, arready}, 0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            end
        end

        axi_write(7'h10, 32'h40, 4'hF, r);
        axi_write(7'h14, 32'hFF, 4'hF, r);
        axi_write(7'h18, 32'h00, 4'hF, r);
        axi_write(7'h00, 32'h01, 4'hF, r);
        repeat (300) @(negedge clk);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(led[0]); c1 += int'(led[1]); c2 += int'(led[2]); c3 += int'(led[3]);
        end
        check("pwm_duty40", c0, 64);
        check("pwm_dutyFF", c1, 256);
        check("pwm_duty00_ch2", c2, 0);
        check("pwm_duty00_ch3", c3, 0);
        axi_read(7'h04, d, r);
        check("status_rresp", 32'(r), 32'(OK));
        check("status_led", d & 32'hFFFF_FFFE, 32'h2);

        wait_rise(0, 600, "glitch_rise");
        c0 = 0;
        fork
            repeat (256) begin
                c0 += int'(led[0]);
                @(negedge clk);
            end
            begin
                repeat (100) @(negedge clk);
                axi_write(7'h10, 32'h80, 4'hF, r);
            end
        join
        check("glitch_cur_period", c0, 64);
        c0 = 0;
        repeat (256) begin
            c0 += int'(led[0]);
            @(negedge clk);
        end
        check("glitch_next_period", c0, 128);

        @(posedge clk); #1;
        awaddr = 7'h10; wdata = 32'h80; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            bad += int'(awready || wready);
        end
        check("aw_alone_waits", bad, 0);
        @(posedge clk); #1;
        wvalid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20 && cnt == 0; k++) begin
            @(negedge clk);
            cnt += int'(awready && wready);
        end
        if (cnt == 0) timeout("hs_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        c1 = 0;
        repeat (5) begin
            @(negedge clk);
            c1 += int'(bvalid);
            cnt += int'(awready);
        end
        check("hs_single_accept", cnt, 1);
        check("hs_bvalid_held", c1, 5);
        check("hs_bresp", 32'(bresp), 32'(OK));
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("hs_bvalid_drop", 32'(bvalid), 0);

        @(posedge clk); #1;
        awaddr = 7'h10; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 7'h10; arvalid = 1'b1; rready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20 && cnt == 0; k++) begin
            @(negedge clk);
            cnt += int'(awready && arready);
        end
        check("rw_same_cycle_accept", cnt, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("rw_rvalid", 32'(rvalid), 1);
        check("rw_old_data", rdata, 32'h80);
        check("rw_bresp", {31'b0, bvalid}, 1);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        axi_read(7'h10, d, r);
        check("rw_new_data", d, 32'h11);

        axi_write(7'h00, 32'h0, 4'hF, r);
        @(negedge clk);
        check("en_clear_led", 32'(led), 0);
        c1 = 0;
        repeat (50) begin
            @(negedge clk);
            c1 += int'(led != 0);
        end
        check("en_clear_hold", c1, 0);

        axi_write(7'h08, 32'h3, 4'hF, r);
        axi_write(7'h00, 32'h1, 4'hF, r);
        wait_rise(0, 2500, "presc_rise");
        c0 = 0;
        for (int k = 0; k < 2000 && led[0]; k++) begin
            c0++;
            @(negedge clk);
        end
        c2 = 0;
        for (int k = 0; k < 2000 && !led[0]; k++) begin
            c2++;
            @(negedge clk);
        end
        check("presc_high_run", c0, 68);
        check("presc_low_run", c2, 956);

        @(posedge clk); #1;
        awaddr = 7'h10; wdata = 32'h33; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 7'h08; arvalid = 1'b1; rready = 1'b0;
        for (int k = 0; k < 20 && !(bvalid && rvalid); k++) @(negedge clk);
        if (!(bvalid && rvalid)) timeout("midrst_pending");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; aresetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_bvalid", 32'(bvalid), 0);
        check("midrst_rvalid", 32'(rvalid), 0);
        check("midrst_led", 32'(led), 0);
        #1 aresetn = 1'b1;
        axi_read(7'h10, d, r);
        check("midrst_duty0", d, 0);
        axi_read(7'h08, d, r);
        check("midrst_prescale", d, 0);
        axi_read(7'h00, d, r);
        check("midrst_ctrl", d, 0);

`ifdef LED_BLINK_EN
        axi_write(7'h10, 32'hFF, 4'hF, r);
        axi_write(7'h14, 32'hFF, 4'hF, r);
        axi_write(7'h0C, 32'h1, 4'hF, r);
        axi_write(7'h00, 32'h11, 4'hF, r);
        wait_rise(0, 3000, "blink_rise");
        c0 = 0; c1 = 0;
        repeat (512) begin
            c0 += int'(led[0]); c1 += int'(led[1]);
            @(negedge clk);
        end
        c2 = 0;
        repeat (512) begin
            c2 += int'(led[0]); c1 += int'(led[1]);
            @(negedge clk);
        end
        check("blink_on_phase", c0, 512);
        check("blink_off_phase", c2, 0);
        check("blink_unmasked", c1, 1024);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
